// File: rtl/cook_timer.sv
// BCD MM:SS microwave countdown timer: keypad entry by left shift, counts down
// once per TICKS_PER_SEC clocks while mag_on is high, flags expiry at 00:00.
module cook_timer #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       mag_on,
  output logic       timer_done,
  output logic       done_pulse,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t        cur;
  logic [PW-1:0] prescaler;
  logic          time_zero;
  logic          at_one;
  logic          accept;
  logic          can_count;
  logic          wrap;
  logic [3:0]    d_mt;
  logic [3:0]    d_mo;
  logic [3:0]    d_st;
  logic [3:0]    d_so;

  assign state = cur;

  // Entry/count qualifiers and the one-second BCD borrow chain
  always_comb begin
    time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    at_one    = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
    accept    = digit_valid && !mag_on && (digit_in <= 4'd9) &&
                ((cur == IDLE) || (cur == DONE));
    // The edge that enters RUNNING already counts as a prescaler tick
    can_count = mag_on && !time_zero && (cur != DONE);
    wrap      = (prescaler == LAST);
    d_mt      = min_tens;
    d_mo      = min_ones;
    d_st      = sec_tens;
    d_so      = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      d_so = 4'd9;
      if (sec_tens == 4'd0) begin
        d_st = 4'd5;
        if (min_ones == 4'd0) begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end else begin
          d_mo = min_ones - 4'd1;
        end
      end else begin
        d_st = sec_tens - 4'd1;
      end
    end else begin
      d_st = sec_tens;
    end
  end

  // Timer state machine, display digits and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= IDLE;
      prescaler  <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
    end else if (!clearn) begin
      cur        <= IDLE;
      prescaler  <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (accept) begin
        min_tens   <= min_ones;
        min_ones   <= sec_tens;
        sec_tens   <= sec_ones;
        sec_ones   <= digit_in;
        timer_done <= ({min_ones, sec_tens, sec_ones, digit_in} == 16'h0000);
        cur        <= IDLE;
      end else if (can_count) begin
        cur <= RUNNING;
        if (wrap) begin
          prescaler  <= '0;
          min_tens   <= d_mt;
          min_ones   <= d_mo;
          sec_tens   <= d_st;
          sec_ones   <= d_so;
          timer_done <= at_one;
          if (at_one) begin
            cur        <= DONE;
            done_pulse <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end else if (cur == RUNNING) begin
        // Prescaler deliberately holds so resume continues mid-second
        cur <= PAUSED;
      end
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICKS_PER_SEC=4: table of vectors plus
// hand-written pause/resume, clear, async reset and zero-start sequences.
module tb_cook_timer;

  logic       clk;
  logic       rst;
  logic       clearn;
  logic       digit_valid;
  logic [3:0] digit_in;
  logic       mag_on;
  logic       timer_done;
  logic       done_pulse;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;

  int total;
  int bad;

  typedef struct {
    logic        clr;
    logic        dv;
    logic [3:0]  din;
    logic        mag;
    int          rep;
    logic [15:0] t;
    logic        done;
    logic        pulse;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clearn      (clearn),
    .digit_valid (digit_valid),
    .digit_in    (digit_in),
    .mag_on      (mag_on),
    .timer_done  (timer_done),
    .done_pulse  (done_pulse),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic c, input logic dv, input logic [3:0] d,
                              input logic m, input int rep, input logic [15:0] t,
                              input logic done, input logic pulse, input logic [1:0] st);
    vec_t v;
    v.clr = c; v.dv = dv; v.din = d; v.mag = m; v.rep = rep;
    v.t = t; v.done = done; v.pulse = pulse; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic c, input logic dv, input logic [3:0] d, input logic m);
    clearn      = c;
    digit_valid = dv;
    digit_in    = d;
    mag_on      = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] t, input logic done,
                     input logic pulse, input logic [1:0] st);
    logic [19:0] got;
    logic [19:0] exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, state};
    exp = {t, done, pulse, st};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got time=%h done=%b pulse=%b state=%b, expected time=%h done=%b pulse=%b state=%b",
               name, got[19:4], got[3], got[2], got[1:0], t, done, pulse, st);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, a, 1'b0);
    step(1'b1, 1'b1, b, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; clearn = 1'b1; digit_valid = 1'b0; digit_in = 4'd0; mag_on = 1'b0;

    // entry, including ignored codes
    add(1, 1, 4'd1,  0, 1, 16'h0001, 0, 0, 2'b00);
    add(1, 1, 4'd3,  0, 1, 16'h0013, 0, 0, 2'b00);
    add(1, 1, 4'd0,  0, 1, 16'h0130, 0, 0, 2'b00);
    add(1, 1, 4'd12, 0, 1, 16'h0130, 0, 0, 2'b00);
    add(1, 1, 4'd15, 0, 1, 16'h0130, 0, 0, 2'b00);
    // borrow chain from 01:00
    add(0, 0, 4'd0,  0, 1, 16'h0000, 1, 0, 2'b00);
    add(1, 1, 4'd1,  0, 1, 16'h0001, 0, 0, 2'b00);
    add(1, 1, 4'd0,  0, 1, 16'h0010, 0, 0, 2'b00);
    add(1, 1, 4'd0,  0, 1, 16'h0100, 0, 0, 2'b00);
    add(1, 0, 4'd0,  1, 3, 16'h0100, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 1, 16'h0059, 0, 0, 2'b01);
    add(1, 1, 4'd5,  1, 3, 16'h0059, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 1, 16'h0058, 0, 0, 2'b01);
    // expiry from 00:02
    add(0, 0, 4'd0,  0, 1, 16'h0000, 1, 0, 2'b00);
    add(1, 1, 4'd2,  0, 1, 16'h0002, 0, 0, 2'b00);
    add(1, 0, 4'd0,  1, 3, 16'h0002, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 1, 16'h0001, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 3, 16'h0001, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 1, 16'h0000, 1, 1, 2'b11);
    add(1, 0, 4'd0,  1, 1, 16'h0000, 1, 0, 2'b11);
    add(1, 1, 4'd4,  1, 5, 16'h0000, 1, 0, 2'b11);
    add(1, 1, 4'd7,  0, 1, 16'h0007, 0, 0, 2'b00);
    // sec_tens above 5 is legal
    add(1, 1, 4'd9,  0, 1, 16'h0079, 0, 0, 2'b00);
    add(1, 0, 4'd0,  1, 1, 16'h0079, 0, 0, 2'b01);
    add(1, 0, 4'd0,  1, 3, 16'h0078, 0, 0, 2'b01);
    // full borrow 10:00 -> 09:59
    add(0, 0, 4'd0,  0, 1, 16'h0000, 1, 0, 2'b00);
    add(1, 1, 4'd1,  0, 1, 16'h0001, 0, 0, 2'b00);
    add(1, 1, 4'd0,  0, 3, 16'h1000, 0, 0, 2'b00);
    add(1, 0, 4'd0,  1, 4, 16'h0959, 0, 0, 2'b01);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", 16'h0000, 1'b1, 1'b0, 2'b00);
    rst = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("reset_idle", 16'h0000, 1'b1, 1'b0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].rep; k++)
        step(vecs[i].clr, vecs[i].dv, vecs[i].din, vecs[i].mag);
      chk($sformatf("vec%0d", i), vecs[i].t, vecs[i].done, vecs[i].pulse, vecs[i].st);
    end

    // pause/resume keeps the prescaler phase
    load(4'd0, 4'd5);
    repeat (6) step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("pause_pre", 16'h0004, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("pause_enter", 16'h0004, 1'b0, 1'b0, 2'b10);
    repeat (9) step(1'b1, 1'b1, 4'd3, 1'b0);
    chk("pause_hold", 16'h0004, 1'b0, 1'b0, 2'b10);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("resume1", 16'h0004, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("resume2", 16'h0003, 1'b0, 1'b0, 2'b01);

    // clearn mid-run
    load(4'd3, 4'd8);
    repeat (4) step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("run_0037", 16'h0037, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("clear_mid", 16'h0000, 1'b1, 1'b0, 2'b00);

    // clearn wins over expiry edge
    load(4'd0, 4'd1);
    repeat (3) step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("pre_expiry", 16'h0001, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("clear_expiry", 16'h0000, 1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("clear_expiry_after", 16'h0000, 1'b1, 1'b0, 2'b00);

    // async reset between edges
    load(4'd3, 4'd8);
    repeat (4) step(1'b1, 1'b0, 4'd0, 1'b1);
    chk("run_0037b", 16'h0037, 1'b0, 1'b0, 2'b01);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 16'h0000, 1'b1, 1'b0, 2'b00);
    #1 rst = 1'b0;

    // zero start never runs
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      chk($sformatf("zero_start%0d", k), 16'h0000, 1'b1, 1'b0, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
